// File: rtl/z80_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | z80_bus_pkg : shared encodings for the tv80 / DMA memory arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package z80_bus_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_GRANT   = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_COOL    = 3'd4;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DMA = 1'b1;

  // Beat counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_bus_arbiter_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | z80_arb_timer : loadable 8-bit down-counter with zero flag           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module z80_arb_timer
  import z80_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/z80_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | z80_bus_arbiter : shares on-chip memory between tv80 and one DMA     |
// | master. Optional REQ timeout with sticky error: ARB_TIMEOUT_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int HOLD_MAX = 16,
  parameter int CPU_SLOT = 8,
  parameter int ACK_TMO  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_mreq_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_busak_n,
  output logic              cpu_busrq_n,
  output logic [7:0]        cpu_din,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_grant,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              arb_err
);

  localparam logic [CNT_W-1:0] HOLD_MAX_C  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] SLOT_LOAD_C = CNT_W'(CPU_SLOT - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD_C  = CNT_W'(ACK_TMO - 1);

  logic [2:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic             busrq_n_q, busrq_n_d;
  logic             grant_q, grant_d;
  logic             ack_q, ack_d;
  logic             forced_q, forced_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             tmo_fire;
  logic [CNT_W-1:0] beats_nxt;
  logic             at_limit;

  // COOL countdown and REQ timeout share one timer; the two states never overlap.
  z80_arb_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign beats_nxt = dma_req ? sat_inc(beats_q) : beats_q;
  assign at_limit  = (beats_nxt >= HOLD_MAX_C);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    busrq_n_d = busrq_n_q;
    grant_d   = grant_q;
    ack_d     = 1'b0;
    forced_d  = forced_q;
    beats_d   = beats_q;
    tmr_load  = 1'b0;
    tmr_val   = SLOT_LOAD_C;
    tmr_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dma_req) begin
          state_d   = ST_REQ;
          busrq_n_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = TMO_LOAD_C;
        end
      end
      ST_REQ: begin
        tmr_dec = 1'b1;
        if (!dma_req || (cpu_busak_n && tmo_fire)) begin
          state_d   = ST_RELEASE;
          busrq_n_d = 1'b1;
          forced_d  = 1'b0;
        end else if (!cpu_busak_n) begin
          state_d  = ST_GRANT;
          sel_d    = SEL_DMA;
          grant_d  = 1'b1;
          beats_d  = '0;
          forced_d = 1'b0;
        end
      end
      ST_GRANT: begin
        ack_d   = dma_req;
        beats_d = beats_nxt;
        if (at_limit || !dma_req || cpu_busak_n) begin
          state_d   = ST_RELEASE;
          sel_d     = SEL_CPU;
          grant_d   = 1'b0;
          busrq_n_d = 1'b1;
          forced_d  = at_limit;
        end
      end
      ST_RELEASE: begin
        if (cpu_busak_n) begin
          forced_d = 1'b0;
          if (forced_q) begin
            state_d  = ST_COOL;
            tmr_load = 1'b1;
            tmr_val  = SLOT_LOAD_C;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_COOL: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sel_d     = SEL_CPU;
        busrq_n_d = 1'b1;
        grant_d   = 1'b0;
        forced_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_CPU;
      busrq_n_q <= 1'b1;
      grant_q   <= 1'b0;
      ack_q     <= 1'b0;
      forced_q  <= 1'b0;
      beats_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      busrq_n_q <= busrq_n_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      forced_q  <= forced_d;
      beats_q   <= beats_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic err_q;

  assign tmo_fire = tmr_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_REQ) && dma_req && cpu_busak_n && tmr_zero) begin
      err_q <= 1'b1;
    end
  end

  assign arb_err = err_q;
`else
  assign tmo_fire = 1'b0;
  assign arb_err  = 1'b0;
`endif

  always_comb begin
    if (sel_q == SEL_DMA) begin
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
      mem_we   = dma_req & dma_we;
    end else begin
      mem_addr = cpu_addr[ADDR_W-1:0];
      mem_din  = cpu_dout;
      mem_we   = !cpu_wr_n & !cpu_mreq_n;
    end
  end

  assign cpu_din     = mem_dout;
  assign dma_rdata   = mem_dout;
  assign cpu_busrq_n = busrq_n_q;
  assign dma_grant   = grant_q;
  assign dma_ack     = ack_q;

  // Upper CPU address bits fall outside the on-chip memory window.
  logic unused_addr;
  assign unused_addr = ^cpu_addr[15:ADDR_W];

endmodule
`default_nettype wire
